// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and fetches from imem over req/ack, with stall and redirect handling.
// Optional FETCH_BUF_EN adds a one-entry buffer that holds a fetched word while the pipeline is held.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] PCplus4,
  output logic        IF_flush
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BUF   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_pc_q, drain_pc_d;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

`ifdef FETCH_BUF_EN
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc4_q, buf_pc4_d;
`endif

  assign pc_inc = pc_q + XLEN'(4);
  assign target = {branch_target[XLEN-1:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      drain_pc_q <= RESET_PC;
`ifdef FETCH_BUF_EN
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= RESET_PC + XLEN'(4);
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_pc_q <= drain_pc_d;
`ifdef FETCH_BUF_EN
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
`endif
    end
  end

  // Next-state and IF/ID-facing outputs; a redirect outranks hold and delivery
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_pc_d = drain_pc_q;
`ifdef FETCH_BUF_EN
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
`endif
    imem_req  = 1'b0;
    imem_addr = pc_q;
    instr     = NOP_INSTR;
    PCplus4   = pc_inc;
    IF_flush  = rst_n & branch_taken;

    if (!rst_n) begin
      PCplus4 = RESET_PC + XLEN'(4);
    end else begin
      case (state_q)
        ST_REQ: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          if (branch_taken) begin
            pc_d = target;
            if (!imem_ack) begin
              drain_pc_d = pc_q;
              state_d    = ST_DRAIN;
            end
          end else if (imem_ack) begin
            instr = imem_rdata;
            if (!hold) begin
              pc_d = pc_inc;
            end else begin
`ifdef FETCH_BUF_EN
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_inc;
              pc_d        = pc_inc;
              state_d     = ST_BUF;
`endif
            end
          end
        end

        // Stale fetch must complete at its original address before a new one issues
        ST_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_pc_q;
          if (branch_taken) begin
            pc_d = target;
          end
          if (imem_ack) begin
            state_d = ST_REQ;
          end
        end

`ifdef FETCH_BUF_EN
        ST_BUF: begin
          instr   = buf_instr_q;
          PCplus4 = buf_pc4_q;
          if (branch_taken) begin
            instr   = NOP_INSTR;
            pc_d    = target;
            state_d = ST_REQ;
          end else if (!hold) begin
            state_d = ST_REQ;
          end
        end
`endif

        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Handles stalls from the hazard unit and redirects from ID-stage branch resolution.
- Drives `instr`, `PCplus4` and `IF_flush` directly into the IF/ID pipeline register, which latches them on the same `clk` edge.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0000: bubble pattern presented on `instr` when no valid instruction is delivered.
- `clk` input 1: single clock, all state updates on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `hold` input 1: hazard-unit stall; IF/ID keeps its contents, fetch stage must not advance past undelivered work.
- `branch_taken` input 1: ID-stage redirect request, valid for one cycle.
- `branch_target` input 32: redirect address; bits [1:0] ignored (forced 00).
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch word address, stable while `imem_req`=1 and no ack.
- `imem_ack` input 1: memory response; `imem_rdata` valid in the same cycle; may arrive in the request cycle.
- `imem_rdata` input 32: fetched instruction.
- `instr` output 32: instruction offered to IF/ID.
- `PCplus4` output 32: address of offered instruction + 4.
- `IF_flush` output 1: zero IF/ID instruction this edge.

## Operation
- Registers: `pc` (32), `state`, `drain_pc` (32), plus buffer registers when configured.
- States:
  - `REQ`: request outstanding or about to be issued.
  - `DRAIN`: discarding a stale in-flight fetch after a redirect.
  - `BUF`: holding a captured instruction; present only with `FETCH_BUF_EN`.
- `IF_flush` = `branch_taken` (combinational, gated by `rst_n`); a redirect always has priority over `hold` and over delivery.
- REQ, `imem_req`=1, `imem_addr`=`pc`:
  - branch_taken & ack: `pc`<=target, stay REQ; fetched word dropped, `instr`=NOP_INSTR.
  - branch_taken & !ack: `pc`<=target, `drain_pc`<=old `pc`, go DRAIN.
  - ack & !hold: `instr`=`imem_rdata`, `PCplus4`=`pc`+4, `pc`<=`pc`+4.
  - ack & hold: see Configuration.
  - !ack: `instr`=NOP_INSTR, `PCplus4`=`pc`+4, `pc` unchanged.
- DRAIN:
  - `imem_req`=1 and `imem_addr`=`drain_pc` (address stable until ack); `instr`=NOP_INSTR.
  - On ack: drop data, go REQ.
  - Further `branch_taken` in DRAIN: only updates `pc`.
- Arithmetic: 32-bit modulo; `pc` 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-transaction: outstanding request is abandoned; the memory must tolerate `imem_req` dropping before ack.

## Timing
- While `rst_n`=0, on the sampling edge:
  - `pc`<=RESET_PC, `state`<=REQ, buffer invalid.
  - Outputs forced: `imem_req`=0, `instr`=NOP_INSTR, `IF_flush`=0, `PCplus4`=RESET_PC+4.
- First request is issued in the first cycle with `rst_n`=1.
- Zero-wait memory (ack in request cycle): one instruction per cycle, zero added latency.
- Redirect penalty:
  - Ack coincident with the redirect: 1 bubble.
  - DRAIN needed: 1 + remaining stale-fetch wait cycles.
- `instr`, `PCplus4` and `IF_flush` are combinational from state and memory inputs; no register stage inside this block.

## Configuration
- `FETCH_BUF_EN` defined:
  - Ack & hold in REQ: capture `imem_rdata` and `pc`+4 into the buffer, `pc`<=`pc`+4, go BUF.
  - In BUF: `imem_req`=0, `instr`=buffered word, `PCplus4`=buffered value.
  - Leave BUF for REQ on the first cycle with !hold; that cycle delivers the buffer.
  - `branch_taken` in BUF: discard the buffer, `pc`<=target, go REQ.
- `FETCH_BUF_EN` undefined:
  - Ack & hold: data dropped, `pc` unchanged, same address re-fetched next cycle.
  - `instr` may show `imem_rdata`, but IF/ID ignores it while `hold`=1.

## Test plan
- Reset release, zero-wait memory returning addr as data:
  - `imem_addr` sequence 0,4,8,C.
  - `instr` equals addr each cycle; `PCplus4`=addr+4; no bubbles.
- 3-cycle memory latency: `imem_addr`=0 stable for 3 cycles, `instr`=NOP_INSTR for 2 cycles, then delivery with `PCplus4`=4.
- `branch_taken` with target 32'h0000_0103, asserted while fetch of 8 is pending (ack 2 cycles later):
  - `IF_flush`=1 for one cycle.
  - DRAIN keeps `imem_addr`=8 until ack; data discarded.
  - Next request addr 32'h0000_0100.
- `hold`=1 for 3 cycles during ack of addr 0x10:
  - With `FETCH_BUF_EN`: `imem_req`=0 during hold, buffered word delivered on release, next fetch 0x14.
  - Without `FETCH_BUF_EN`: 0x10 re-fetched each held cycle.
- `branch_taken` and `hold` both asserted: `IF_flush`=1, `pc` updated to target regardless of `hold`.
- PC wrap: RESET_PC=32'hFFFF_FFFC; `PCplus4`=0, next `imem_addr`=0.
